// File: rtl/dec_pkg.sv
// Shared decode definitions: sequencer states,
// addressing-mode fields and opcode class codes.
package dec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    PENALTY,
    EXEC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    M_NONE,
    M_ZP,
    M_ZPI,
    M_ABS,
    M_ABSI
  } mode_e;

  localparam logic [2:0] BBB_IMM0 = 3'b000;
  localparam logic [2:0] BBB_ZP   = 3'b001;
  localparam logic [2:0] BBB_IMM  = 3'b010;
  localparam logic [2:0] BBB_ABS  = 3'b011;
  localparam logic [2:0] BBB_IND  = 3'b100;
  localparam logic [2:0] BBB_ZPX  = 3'b101;
  localparam logic [2:0] BBB_ABSY = 3'b110;
  localparam logic [2:0] BBB_ABSX = 3'b111;

  localparam logic [1:0] CC_00 = 2'b00;
  localparam logic [1:0] CC_01 = 2'b01;
  localparam logic [1:0] CC_10 = 2'b10;
  localparam logic [1:0] CC_11 = 2'b11;

  localparam logic [4:0] OPP_ORA = 5'b00001;
  localparam logic [4:0] OPP_AND = 5'b00101;
  localparam logic [4:0] OPP_EOR = 5'b01001;
  localparam logic [4:0] OPP_ADC = 5'b01101;
  localparam logic [4:0] OPP_STA = 5'b10001;
  localparam logic [4:0] OPP_LDA = 5'b10101;
  localparam logic [4:0] OPP_CMP = 5'b11001;
  localparam logic [4:0] OPP_SBC = 5'b11101;
  localparam logic [4:0] OPP_ASL = 5'b00010;
  localparam logic [4:0] OPP_STX = 5'b10010;
  localparam logic [4:0] OPP_LDX = 5'b10110;

endpackage

// File: rtl/ea_calc.sv
// Effective-address adder: zero-page wrap,
// absolute and indexed forms, page-cross flag.
module ea_calc
  import dec_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic [REG_WIDTH-1:0]  lo,
  input  logic [REG_WIDTH-1:0]  hi,
  input  logic [REG_WIDTH-1:0]  idx,
  input  logic [2:0]            mode,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic                  page_cross
);

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] sum;
  logic [REG_WIDTH-1:0]  zsum;

  // Form every candidate sum and pick by mode.
  always_comb begin
    base       = ADDR_WIDTH'({hi, lo});
    sum        = base + ADDR_WIDTH'(idx);
    zsum       = lo + idx;
    ea         = '0;
    page_cross = 1'b0;
    unique case (mode)
      M_ZP:  ea = ADDR_WIDTH'(lo);
      M_ZPI: ea = ADDR_WIDTH'(zsum);
      M_ABS: ea = base;
      M_ABSI: begin
        ea = sum;
        page_cross =
          sum[ADDR_WIDTH-1:REG_WIDTH] !=
          base[ADDR_WIDTH-1:REG_WIDTH];
      end
      default: ea = '0;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// Opcode acceptance, operand fetch and
// execute handshake for the decode stage.
module decode_sequencer
  import dec_pkg::*;
#(
  parameter int REG_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int OPP_WIDTH    = 5,
  parameter int PAGE_PENALTY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  instr_valid,
  input  logic [REG_WIDTH-1:0]  instr_data,
  output logic                  instr_ready,
  output logic                  byte_req,
  input  logic                  byte_valid,
  input  logic [REG_WIDTH-1:0]  byte_data,
  input  logic [REG_WIDTH-1:0]  x_reg,
  input  logic [REG_WIDTH-1:0]  y_reg,
  output logic                  exec_valid,
  input  logic                  exec_ack,
  output logic [OPP_WIDTH-1:0]  opp,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic [REG_WIDTH-1:0]  imm,
  output logic                  is_imm,
  output logic                  is_acc,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  state_e state_q, state_d;
  mode_e  mode_q, dec_mode;

  logic [OPP_WIDTH-1:0]  opp_q;
  logic [REG_WIDTH-1:0]  lo_q, lo_in, idx;
  logic [ADDR_WIDTH-1:0] ea_q, ea_w;
  logic two_q, is_imm_q, is_acc_q;
  logic use_y_q, err_q;
  logic page_cross;

  logic [2:0] aaa, bbb;
  logic [1:0] cc;
  logic dec_bad, dec_two, dec_zero;
  logic dec_imm, dec_acc, dec_y;
  logic accept, take, in_exec;

  assign aaa = instr_data[7:5];
  assign bbb = instr_data[4:2];
  assign cc  = instr_data[1:0];

  assign accept = (state_q == IDLE) &&
                  instr_valid && !flush;
  assign take = byte_valid && !flush &&
                (state_q == FETCH_LO ||
                 state_q == FETCH_HI);

  // Classify the offered opcode by bbb/cc.
  always_comb begin
    dec_bad  = (cc == CC_11) ||
               (bbb == BBB_IND) ||
               (bbb == BBB_IMM0 && cc == CC_01) ||
               (bbb == BBB_IMM && cc == CC_00);
    dec_mode = M_NONE;
    dec_two  = 1'b0;
    dec_zero = 1'b0;
    dec_imm  = 1'b0;
    dec_acc  = 1'b0;
    dec_y    = (bbb == BBB_ABSY) ||
               ((bbb == BBB_ZPX ||
                 bbb == BBB_ABSX) &&
                cc == CC_10 &&
                (aaa == 3'b100 || aaa == 3'b101));
    if (!dec_bad) begin
      unique case (1'b1)
        (bbb == BBB_IMM0) ||
        (bbb == BBB_IMM && cc == CC_01):
          dec_imm = 1'b1;
        (bbb == BBB_IMM && cc == CC_10): begin
          dec_acc  = 1'b1;
          dec_zero = 1'b1;
        end
        (bbb == BBB_ZP):  dec_mode = M_ZP;
        (bbb == BBB_ZPX): dec_mode = M_ZPI;
        (bbb == BBB_ABS): begin
          dec_mode = M_ABS;
          dec_two  = 1'b1;
        end
        (bbb == BBB_ABSY) ||
        (bbb == BBB_ABSX): begin
          dec_mode = M_ABSI;
          dec_two  = 1'b1;
        end
        default: dec_mode = M_NONE;
      endcase
    end
  end

  assign idx   = use_y_q ? y_reg : x_reg;
  assign lo_in = (state_q == FETCH_LO) ?
                 byte_data : lo_q;

  ea_calc #(
    .REG_WIDTH (REG_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ea (
    .lo        (lo_in),
    .hi        (byte_data),
    .idx       (idx),
    .mode      (mode_q),
    .ea        (ea_w),
    .page_cross(page_cross)
  );

  // Next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = dec_bad  ? DONE :
                    dec_zero ? EXEC : FETCH_LO;
      FETCH_LO:
        if (byte_valid)
          state_d = two_q ? FETCH_HI : EXEC;
      FETCH_HI:
        if (byte_valid)
          state_d = (page_cross &&
                     PAGE_PENALTY != 0) ?
                    PENALTY : EXEC;
      PENALTY: state_d = EXEC;
      EXEC:
        if (exec_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch decode on accept, operands on fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opp_q    <= '0;
      mode_q   <= M_NONE;
      two_q    <= 1'b0;
      is_imm_q <= 1'b0;
      is_acc_q <= 1'b0;
      use_y_q  <= 1'b0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      ea_q     <= '0;
    end else if (accept) begin
      opp_q    <= OPP_WIDTH'({aaa, cc});
      mode_q   <= dec_mode;
      two_q    <= dec_two;
      is_imm_q <= dec_imm;
      is_acc_q <= dec_acc;
      use_y_q  <= dec_y;
      err_q    <= dec_bad;
      lo_q     <= '0;
      ea_q     <= '0;
    end else if (take) begin
      lo_q <= lo_in;
      ea_q <= ea_w;
    end
  end

  assign in_exec     = (state_q == EXEC);
  assign instr_ready = (state_q == IDLE) && !flush;
  assign byte_req    = (state_q == FETCH_LO) ||
                       (state_q == FETCH_HI);
  assign exec_valid  = in_exec;
  assign opp    = in_exec ? opp_q : '0;
  assign ea     = in_exec ? ea_q  : '0;
  assign is_imm = in_exec && is_imm_q;
  assign is_acc = in_exec && is_acc_q;
  assign imm    = is_imm ? lo_q : '0;
  assign done   = (state_q == DONE) && !err_q;
  assign err    = (state_q == DONE) && err_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer,
// default and no-penalty builds side by side.
module tb_decode_sequencer;
  import dec_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic instr_valid = 1'b0;
  logic [7:0] instr_data = '0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic [7:0] x_reg = '0;
  logic [7:0] y_reg = '0;
  logic exec_ack = 1'b0;

  logic instr_ready, byte_req, exec_valid;
  logic [4:0] opp;
  logic [15:0] ea;
  logic [7:0] imm;
  logic is_imm, is_acc, done, err, busy;

  logic instr_ready0, byte_req0, exec_valid0;
  logic [4:0] opp0;
  logic [15:0] ea0;
  logic [7:0] imm0;
  logic is_imm0, is_acc0, done0, err0, busy0;

  always #5 clk = ~clk;

  decode_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_ready(instr_ready),
    .byte_req(byte_req), .byte_valid(byte_valid),
    .byte_data(byte_data),
    .x_reg(x_reg), .y_reg(y_reg),
    .exec_valid(exec_valid), .exec_ack(exec_ack),
    .opp(opp), .ea(ea), .imm(imm),
    .is_imm(is_imm), .is_acc(is_acc),
    .done(done), .err(err), .busy(busy)
  );

  decode_sequencer #(.PAGE_PENALTY(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_ready(instr_ready0),
    .byte_req(byte_req0), .byte_valid(byte_valid),
    .byte_data(byte_data),
    .x_reg(x_reg), .y_reg(y_reg),
    .exec_valid(exec_valid0), .exec_ack(exec_ack),
    .opp(opp0), .ea(ea0), .imm(imm0),
    .is_imm(is_imm0), .is_acc(is_acc0),
    .done(done0), .err(err0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  int t_exec, t_exec0, t_done, t_err, t_rdy, nreq;
  logic [15:0] ea_s, ea0_s;
  logic [7:0]  imm_s;
  logic [4:0]  opp_s;
  logic        imm_f, acc_f;

  // Times are edge numbers after the accept edge T
  // at which a signal is first sampled high.
  task automatic run_op(input logic [7:0] op,
                        input logic [7:0] b0,
                        input logic [7:0] b1,
                        input logic [7:0] xv,
                        input logic [7:0] yv);
    int cnt;
    cnt = 0;
    t_exec = -1; t_exec0 = -1; t_done = -1;
    t_err = -1; t_rdy = -1; nreq = 0;
    ea_s = '0; ea0_s = '0; imm_s = '0;
    opp_s = '0; imm_f = 0; acc_f = 0;
    @(negedge clk);
    instr_valid = 1; instr_data = op;
    x_reg = xv; y_reg = yv;
    byte_valid = 1; exec_ack = 1; byte_data = b0;
    @(posedge clk);
    #1 instr_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (exec_valid && t_exec < 0) begin
        t_exec = k; ea_s = ea; imm_s = imm;
        opp_s = opp; imm_f = is_imm;
        acc_f = is_acc;
      end
      if (exec_valid0 && t_exec0 < 0) begin
        t_exec0 = k; ea0_s = ea0;
      end
      if (done && t_done < 0) t_done = k;
      if (err && t_err < 0) t_err = k;
      if (instr_ready && t_rdy < 0) t_rdy = k;
      byte_data = (cnt == 0) ? b0 : b1;
      if (byte_req) begin
        nreq++;
        cnt++;
      end
    end
  endtask

  initial begin
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_exec", exec_valid, 0);
    check("rst_breq", byte_req, 0);
    check("rst_ea", ea, 0);
    check("rst_opp", opp, 0);
    @(negedge clk);
    reset_n = 1;

    // LDA #$42
    run_op(8'hA9, 8'h42, 8'h00, 8'h00, 8'h00);
    check("lda_imm_exec_t", t_exec, 2);
    check("lda_imm_done_t", t_done, 3);
    check("lda_imm_rdy_t", t_rdy, 4);
    check("lda_imm_isimm", imm_f, 1);
    check("lda_imm_imm", imm_s, 8'h42);
    check("lda_imm_opp", opp_s, 5'b10101);
    check("lda_imm_nreq", nreq, 1);

    // STA $12,X with X=F0 wraps in page zero
    run_op(8'h95, 8'h12, 8'h00, 8'hF0, 8'h00);
    check("sta_zpx_ea", ea_s, 16'h0002);
    check("sta_zpx_exec_t", t_exec, 2);
    check("sta_zpx_opp", opp_s, OPP_STA);
    check("sta_zpx_isimm", imm_f, 0);

    // LDX $10,Y picks Y
    run_op(8'hB6, 8'h10, 8'h00, 8'h20, 8'h05);
    check("ldx_zpy_ea", ea_s, 16'h0015);

    // LDA $1234
    run_op(8'hAD, 8'h34, 8'h12, 8'h00, 8'h00);
    check("lda_abs_exec_t", t_exec, 3);
    check("lda_abs_ea", ea_s, 16'h1234);
    check("lda_abs_nreq", nreq, 2);

    // LDA $12FF,X with X=1 crosses a page
    run_op(8'hBD, 8'hFF, 8'h12, 8'h01, 8'h00);
    check("absx_cross_ea", ea_s, 16'h1300);
    check("absx_cross_exec_t", t_exec, 4);
    check("absx_nopen_exec_t", t_exec0, 3);
    check("absx_nopen_ea", ea0_s, 16'h1300);

    // LDA $2000,Y with Y=10, no cross
    run_op(8'hB9, 8'h00, 8'h20, 8'h01, 8'h10);
    check("absy_ea", ea_s, 16'h2010);
    check("absy_exec_t", t_exec, 3);

    // ASL A
    run_op(8'h0A, 8'h00, 8'h00, 8'h00, 8'h00);
    check("asl_acc_exec_t", t_exec, 1);
    check("asl_acc_isacc", acc_f, 1);
    check("asl_acc_nreq", nreq, 0);
    check("asl_acc_opp", opp_s, OPP_ASL);

    // Unsupported opcodes
    run_op(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    check("op_ff_err_t", t_err, 1);
    check("op_ff_exec_t", t_exec, -1);
    check("op_ff_nreq", nreq, 0);
    check("op_ff_done_t", t_done, -1);
    check("op_ff_rdy_t", t_rdy, 2);
    run_op(8'hA1, 8'h00, 8'h00, 8'h00, 8'h00);
    check("op_a1_err_t", t_err, 1);
    check("op_a1_exec_t", t_exec, -1);
    check("op_a1_nreq", nreq, 0);

    // Stall in FETCH_HI, then async reset
    @(negedge clk);
    instr_valid = 1; instr_data = 8'hAD;
    byte_valid = 1; byte_data = 8'h34;
    exec_ack = 0;
    @(posedge clk);
    #1 instr_valid = 0;
    @(posedge clk);
    #1 byte_valid = 0;
    @(negedge clk);
    check("stall_breq", byte_req, 1);
    @(negedge clk);
    check("stall_hold_breq", byte_req, 1);
    check("stall_hold_busy", busy, 1);
    #2 reset_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_breq", byte_req, 0);
    check("arst_ready", instr_ready, 1);
    check("arst_exec", exec_valid, 0);
    check("arst_ea", ea, 0);

    // First edge after reset accepts
    @(negedge clk);
    reset_n = 1;
    instr_valid = 1; instr_data = 8'hA9;
    @(posedge clk);
    #1 instr_valid = 0;
    check("post_rst_accept", busy, 1);
    check("post_rst_breq", byte_req, 1);

    // Flush from FETCH_LO
    @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    check("flush_lo_busy", busy, 0);

    // Flush beats exec_ack in EXEC
    @(negedge clk);
    instr_valid = 1; instr_data = 8'h0A;
    @(posedge clk);
    #1 instr_valid = 0;
    check("flush_ex_valid", exec_valid, 1);
    @(negedge clk);
    flush = 1; exec_ack = 1;
    @(posedge clk);
    #1 flush = 0; exec_ack = 0;
    check("flush_ex_busy", busy, 0);
    check("flush_ex_done", done, 0);
    @(negedge clk);
    check("flush_ex_done2", done, 0);

    // Flush with instr_valid: no accept
    flush = 1; instr_valid = 1;
    instr_data = 8'hA9;
    @(posedge clk);
    #1 flush = 0; instr_valid = 0;
    check("flush_vs_valid", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
